// File: rtl/BwaMemDefines.sv
// Shared definitions for the BWA-MEM seeding datapath.
// Symbol encoding, read-id width and the dispatcher slot states.
package BwaMemDefines;

  typedef logic [2:0] Symbol;

  localparam Symbol sym_A = 3'd0;
  localparam Symbol sym_C = 3'd1;
  localparam Symbol sym_G = 3'd2;
  localparam Symbol sym_T = 3'd3;
  localparam Symbol sym_N = 3'd4;

  localparam int RID_W = 32;

  typedef enum logic [1:0] {
    S_FREE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2
  } slot_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first request at or after ptr,
// searched modulo N.
module rr_arbiter #(
  parameter int N = 4,
  localparam int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic          gnt_valid
);

  logic [PW-1:0] idx;

  always_comb begin
    gnt       = '0;
    gnt_valid = 1'b0;
    idx       = '0;
    for (int i = 0; i < N; i++) begin
      idx = PW'((int'(ptr) + i) % N);
      if (req[idx] && !gnt_valid) begin
        gnt[idx]  = 1'b1;
        gnt_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/read_dispatch.sv
// Spreads incoming reads over NUM_ENG seeding engines, holds each
// engine's read stable while it runs and reports end of batch.
module read_dispatch
  import BwaMemDefines::*;
#(
  parameter int NUM_ENG  = 4,
  parameter int READ_LEN = 76,
  parameter int CNT_W    = 32
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                enable,
  input  Symbol [READ_LEN-1:0]                s_read,
  input  logic [RID_W-1:0]                    s_read_id,
  input  logic                                s_read_last,
  input  logic                                s_read_valid,
  output logic                                s_read_ready,
  output Symbol [NUM_ENG-1:0][READ_LEN-1:0]   eng_read,
  output logic [NUM_ENG-1:0][RID_W-1:0]       eng_read_id,
  output logic [NUM_ENG-1:0]                  eng_start,
  input  logic [NUM_ENG-1:0]                  eng_finish,
  output logic                                batch_done,
  output logic [CNT_W-1:0]                    dispatched_cnt,
  output logic [CNT_W-1:0]                    completed_cnt,
  output logic                                err_spurious
);

  localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

  slot_state_t          state [NUM_ENG];
  logic [PW-1:0]        rr_ptr;
  logic [PW-1:0]        gidx;
  logic                 last_seen;
  logic [NUM_ENG-1:0]   free_vec;
  logic [NUM_ENG-1:0]   run_vec;
  logic [NUM_ENG-1:0]   gnt;
  logic [NUM_ENG-1:0]   fin_ok;
  logic                 gnt_valid;
  logic                 accept;
  logic [CNT_W-1:0]     fin_cnt;

  always_comb begin
    free_vec  = '0;
    run_vec   = '0;
    eng_start = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      free_vec[k]  = (state[k] == S_FREE);
      run_vec[k]   = (state[k] == S_RUN);
      eng_start[k] = (state[k] == S_LOAD);
    end
  end

  rr_arbiter #(.N(NUM_ENG)) u_arb (
    .req       (free_vec),
    .ptr       (rr_ptr),
    .gnt       (gnt),
    .gnt_valid (gnt_valid)
  );

  assign s_read_ready = enable && (|free_vec) && !rst;
  assign accept       = s_read_valid && s_read_ready && gnt_valid;
  assign batch_done   = last_seen && (&free_vec);
  assign fin_ok       = eng_finish & run_vec;

  always_comb begin
    gidx    = '0;
    fin_cnt = '0;
    for (int k = 0; k < NUM_ENG; k++) begin
      if (gnt[k]) gidx = PW'(k);
      fin_cnt = fin_cnt + CNT_W'(fin_ok[k]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < NUM_ENG; k++) begin
        state[k]       <= S_FREE;
        eng_read[k]    <= {READ_LEN{sym_N}};
        eng_read_id[k] <= '0;
      end
      rr_ptr         <= '0;
      last_seen      <= 1'b0;
      dispatched_cnt <= '0;
      completed_cnt  <= '0;
      err_spurious   <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_ENG; k++) begin
        unique case (state[k])
          S_FREE: begin
            if (accept && gnt[k]) begin
              state[k]       <= S_LOAD;
              eng_read[k]    <= s_read;
              eng_read_id[k] <= s_read_id;
            end
          end
          S_LOAD: state[k] <= S_RUN;
          S_RUN:  if (eng_finish[k]) state[k] <= S_FREE;
          default: state[k] <= S_FREE;
        endcase
      end
      if (accept)
        rr_ptr <= (int'(gidx) == NUM_ENG - 1) ? '0 : gidx + 1'b1;
      // a same-cycle accept of a new batch keeps last_seen only if it is itself last
      if (accept && s_read_last)
        last_seen <= 1'b1;
      else if (batch_done)
        last_seen <= 1'b0;
      dispatched_cnt <= dispatched_cnt + CNT_W'(accept);
      completed_cnt  <= completed_cnt + fin_cnt;
      if (|(eng_finish & ~run_vec))
        err_spurious <= 1'b1;
    end
  end

endmodule

// File: tb/tb_read_dispatch.sv
// Self-checking bench for read_dispatch: directed scenarios plus a
// randomized run against an abstract slot-occupancy model.
module tb_read_dispatch;
  import BwaMemDefines::*;

  localparam int N  = 4;
  localparam int L  = 76;
  localparam int CW = 32;

  logic clk = 1'b0;
  logic rst, enable;
  Symbol [L-1:0] s_read;
  logic [RID_W-1:0] s_read_id;
  logic s_read_last, s_read_valid, s_read_ready;
  Symbol [N-1:0][L-1:0] eng_read;
  logic [N-1:0][RID_W-1:0] eng_read_id;
  logic [N-1:0] eng_start, eng_finish;
  logic batch_done, err_spurious;
  logic [CW-1:0] dispatched_cnt, completed_cnt;

  int total = 0;
  int bad = 0;
  int bd_cnt = 0;

  always #5 clk = ~clk;

  read_dispatch #(.NUM_ENG(N), .READ_LEN(L), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .s_read(s_read), .s_read_id(s_read_id),
    .s_read_last(s_read_last), .s_read_valid(s_read_valid),
    .s_read_ready(s_read_ready),
    .eng_read(eng_read), .eng_read_id(eng_read_id),
    .eng_start(eng_start), .eng_finish(eng_finish),
    .batch_done(batch_done),
    .dispatched_cnt(dispatched_cnt), .completed_cnt(completed_cnt),
    .err_spurious(err_spurious)
  );

  always @(negedge clk) if (batch_done === 1'b1) bd_cnt++;

  // Abstract model: which engines hold a read, which owe a start pulse
  bit m_busy [N];
  bit m_due [N];
  logic [RID_W-1:0] m_id [N];
  Symbol [L-1:0] m_rd [N];
  int m_ptr;
  bit m_last;
  logic [CW-1:0] m_disp, m_comp;
  bit m_err;
  Symbol [L-1:0] all_n;

  function automatic bit m_all_free();
    for (int k = 0; k < N; k++) if (m_busy[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit m_ready();
    bit any;
    any = 1'b0;
    for (int k = 0; k < N; k++) if (!m_busy[k]) any = 1'b1;
    return enable && !rst && any;
  endfunction

  function automatic bit m_bd();
    return m_last && m_all_free();
  endfunction

  function automatic logic [N-1:0] m_start_vec();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = m_due[k];
    return v;
  endfunction

  task automatic rand_read();
    for (int i = 0; i < L; i++) s_read[i] = Symbol'($urandom_range(0, 4));
  endtask

  task automatic cycle();
    bit acc, bd;
    int g;
    @(posedge clk);
    acc = s_read_valid && m_ready();
    bd  = m_bd();
    g   = -1;
    if (rst) begin
      for (int k = 0; k < N; k++) begin
        m_busy[k] = 0; m_due[k] = 0; m_id[k] = '0; m_rd[k] = all_n;
      end
      m_ptr = 0; m_last = 0; m_disp = '0; m_comp = '0; m_err = 0;
    end else begin
      if (acc)
        for (int i = 0; i < N; i++)
          if (g < 0 && !m_busy[(m_ptr + i) % N]) g = (m_ptr + i) % N;
      for (int k = 0; k < N; k++) begin
        if (eng_finish[k]) begin
          if (m_busy[k] && !m_due[k]) begin
            m_busy[k] = 0;
            m_comp++;
          end else m_err = 1;
        end
        m_due[k] = 0;
      end
      if (acc) begin
        m_busy[g] = 1; m_due[g] = 1;
        m_id[g] = s_read_id; m_rd[g] = s_read;
        m_ptr = (g + 1) % N;
        m_disp++;
      end
      if (acc && s_read_last) m_last = 1;
      else if (bd) m_last = 0;
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1; s_read_valid = 0; eng_finish = '0;
    cycle();
    rst = 0;
  endtask

  task automatic test_reset();
    do_reset();
    rst = 1;
    cycle();
    if (s_read_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", s_read_ready); end
    total++;
    if (eng_start !== '0 || batch_done !== 1'b0 || err_spurious !== 1'b0) begin
      bad++; $display("FAIL reset_flags start=%b bd=%b err=%b exp=0", eng_start, batch_done, err_spurious);
    end
    total++;
    if (dispatched_cnt !== '0 || completed_cnt !== '0) begin
      bad++; $display("FAIL reset_cnt disp=%0d comp=%0d exp=0", dispatched_cnt, completed_cnt);
    end
    total++;
    for (int k = 0; k < N; k++) begin
      if (eng_read[k] !== all_n || eng_read_id[k] !== '0) begin
        bad++; $display("FAIL reset_buf eng=%0d id=%0h read=%h exp id=0 read=%h", k, eng_read_id[k], eng_read[k], all_n);
      end
      total++;
    end
    rst = 0;
    #1;
    if (s_read_ready !== 1'b1) begin bad++; $display("FAIL reset_release_ready got=%b exp=1", s_read_ready); end
    total++;
  endtask

  task automatic test_fill();
    logic [N-1:0] exp_s;
    for (int i = 0; i < N; i++) begin
      s_read_valid = 1; s_read_id = RID_W'(10 + i); s_read_last = 0; rand_read();
      cycle();
      exp_s = '0; exp_s[i] = 1'b1;
      if (eng_start !== exp_s) begin bad++; $display("FAIL fill_start i=%0d got=%b exp=%b", i, eng_start, exp_s); end
      total++;
      if (eng_read_id[i] !== RID_W'(10 + i) || eng_read[i] !== m_rd[i]) begin
        bad++; $display("FAIL fill_buf eng=%0d id=%0d exp=%0d", i, eng_read_id[i], 10 + i);
      end
      total++;
    end
    s_read_id = 14;
    for (int c = 0; c < 2; c++) begin
      #1;
      if (s_read_ready !== 1'b0) begin bad++; $display("FAIL fill_full_ready c=%0d got=%b exp=0", c, s_read_ready); end
      total++;
      cycle();
    end
    if (dispatched_cnt !== 32'd4) begin bad++; $display("FAIL fill_disp got=%0d exp=4", dispatched_cnt); end
    total++;
  endtask

  task automatic test_round_robin();
    s_read_valid = 0; eng_finish = 4'b0100;
    #1;
    if (s_read_ready !== 1'b0) begin bad++; $display("FAIL rr_ready_fin_cycle got=%b exp=0", s_read_ready); end
    total++;
    cycle();
    eng_finish = '0;
    if (s_read_ready !== 1'b1 || completed_cnt !== 32'd1) begin
      bad++; $display("FAIL rr_after_fin ready=%b comp=%0d exp ready=1 comp=1", s_read_ready, completed_cnt);
    end
    total++;
    s_read_valid = 1; s_read_id = 20; rand_read();
    cycle();
    s_read_valid = 0;
    if (eng_start !== 4'b0100 || eng_read_id[2] !== 32'd20) begin
      bad++; $display("FAIL rr_id20 start=%b id2=%0d exp start=0100 id=20", eng_start, eng_read_id[2]);
    end
    total++;
    eng_finish = 4'b1001;
    cycle();
    eng_finish = '0;
    if (completed_cnt !== 32'd3) begin bad++; $display("FAIL rr_pair_comp got=%0d exp=3", completed_cnt); end
    total++;
    s_read_valid = 1; s_read_id = 21; rand_read();
    cycle();
    if (eng_start !== 4'b1000 || eng_read_id[3] !== 32'd21) begin
      bad++; $display("FAIL rr_id21 start=%b id3=%0d exp start=1000 id=21", eng_start, eng_read_id[3]);
    end
    total++;
    s_read_id = 22; rand_read();
    cycle();
    s_read_valid = 0;
    if (eng_start !== 4'b0001 || eng_read_id[0] !== 32'd22) begin
      bad++; $display("FAIL rr_id22 start=%b id0=%0d exp start=0001 id=22", eng_start, eng_read_id[0]);
    end
    total++;
  endtask

  task automatic test_buffer_stability();
    for (int c = 0; c < 6; c++) begin
      rand_read(); s_read_valid = c[0];
      eng_finish = (c == 5) ? 4'b1111 : 4'b0000;
      cycle();
      for (int k = 0; k < N; k++) begin
        if (eng_read[k] !== m_rd[k]) begin
          bad++; $display("FAIL stab eng=%0d c=%0d got=%h exp=%h", k, c, eng_read[k], m_rd[k]);
        end
        total++;
      end
    end
    s_read_valid = 0; eng_finish = '0;
    if (completed_cnt !== 32'd7) begin bad++; $display("FAIL stab_comp got=%0d exp=7", completed_cnt); end
    total++;
  endtask

  task automatic test_batch();
    logic [N-1:0] ord [3];
    do_reset();
    bd_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      s_read_valid = 1; s_read_id = RID_W'(30 + i); s_read_last = (i == 2); rand_read();
      cycle();
    end
    s_read_valid = 0; s_read_last = 0;
    ord[0] = 4'b0010; ord[1] = 4'b0001; ord[2] = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      eng_finish = ord[i];
      cycle();
      if (batch_done !== (i == 2)) begin
        bad++; $display("FAIL batch_done_step i=%0d got=%b exp=%b", i, batch_done, i == 2);
      end
      total++;
    end
    eng_finish = '0;
    if (dispatched_cnt !== 32'd3 || completed_cnt !== 32'd3) begin
      bad++; $display("FAIL batch_cnt disp=%0d comp=%0d exp=3/3", dispatched_cnt, completed_cnt);
    end
    total++;
    cycle();
    cycle();
    if (bd_cnt !== 1) begin bad++; $display("FAIL batch_pulses got=%0d exp=1", bd_cnt); end
    total++;
  endtask

  task automatic test_enable_reset();
    do_reset();
    for (int i = 0; i < 2; i++) begin
      s_read_valid = 1; s_read_id = RID_W'(40 + i); rand_read();
      cycle();
    end
    enable = 0;
    #1;
    if (s_read_ready !== 1'b0) begin bad++; $display("FAIL en_ready got=%b exp=0", s_read_ready); end
    total++;
    cycle();
    if (dispatched_cnt !== 32'd2 || eng_start !== '0) begin
      bad++; $display("FAIL en_no_accept disp=%0d start=%b exp 2/0", dispatched_cnt, eng_start);
    end
    total++;
    enable = 1; s_read_valid = 0; rst = 1;
    cycle();
    rst = 0;
    if (dispatched_cnt !== '0 || eng_start !== '0 || eng_read_id[0] !== '0 || eng_read[1] !== all_n) begin
      bad++; $display("FAIL midrst disp=%0d start=%b id0=%0d exp zeros", dispatched_cnt, eng_start, eng_read_id[0]);
    end
    total++;
    eng_finish = 4'b0001;
    cycle();
    eng_finish = '0;
    if (err_spurious !== 1'b1 || completed_cnt !== '0) begin
      bad++; $display("FAIL spurious err=%b comp=%0d exp err=1 comp=0", err_spurious, completed_cnt);
    end
    total++;
  endtask

  task automatic test_counter_wrap();
    do_reset();
    force dut.dispatched_cnt = '1;
    #1;
    release dut.dispatched_cnt;
    m_disp = '1;
    #1;
    if (dispatched_cnt !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_preload got=%h exp=ffffffff", dispatched_cnt); end
    total++;
    s_read_valid = 1; s_read_id = 50; rand_read();
    cycle();
    s_read_valid = 0;
    if (dispatched_cnt !== '0) begin bad++; $display("FAIL wrap got=%h exp=0", dispatched_cnt); end
    total++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      enable = ($urandom_range(0, 9) != 0);
      s_read_valid = $urandom_range(0, 1);
      s_read_last = ($urandom_range(0, 7) == 0);
      s_read_id = $urandom;
      rand_read();
      for (int k = 0; k < N; k++)
        eng_finish[k] = (m_busy[k] && !m_due[k] && $urandom_range(0, 3) == 0) ||
                        ($urandom_range(0, 199) == 0);
      #1;
      if (s_read_ready !== m_ready()) begin
        bad++; $display("FAIL rnd_ready c=%0d got=%b exp=%b", c, s_read_ready, m_ready());
      end
      total++;
      cycle();
      if (eng_start !== m_start_vec()) begin
        bad++; $display("FAIL rnd_start c=%0d got=%b exp=%b", c, eng_start, m_start_vec());
      end
      total++;
      if (batch_done !== m_bd()) begin
        bad++; $display("FAIL rnd_bd c=%0d got=%b exp=%b", c, batch_done, m_bd());
      end
      total++;
      if (dispatched_cnt !== m_disp || completed_cnt !== m_comp || err_spurious !== m_err) begin
        bad++; $display("FAIL rnd_cnt c=%0d disp=%0d/%0d comp=%0d/%0d err=%b/%b",
                        c, dispatched_cnt, m_disp, completed_cnt, m_comp, err_spurious, m_err);
      end
      total++;
      for (int k = 0; k < N; k++) begin
        if (eng_read_id[k] !== m_id[k] || eng_read[k] !== m_rd[k]) begin
          bad++; $display("FAIL rnd_buf c=%0d eng=%0d id=%h exp=%h", c, k, eng_read_id[k], m_id[k]);
        end
        total++;
      end
    end
    eng_finish = '0; s_read_valid = 0;
  endtask

  initial begin
    for (int i = 0; i < L; i++) all_n[i] = sym_N;
    rst = 1; enable = 1; s_read_valid = 0; s_read_last = 0;
    s_read_id = '0; eng_finish = '0; s_read = all_n;
    test_reset();
    test_fill();
    test_round_robin();
    test_buffer_stability();
    test_batch();
    test_enable_reset();
    test_counter_wrap();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/read_dispatch.md
Name: read_dispatch

Overview:
- Schedules an incoming stream of reads across NUM_ENG parallel read-to-MEM engine instances (SmpFwd/BiDir/Reseed seeding pipeline).
- Holds a stable per-engine copy of each read and its id, and pulses each engine's start.
- Tracks each engine through to its finish pulse and reports end-of-batch.
- Sits between the host read-fetch stream and the engine array; engine configuration inputs and result streams are outside its scope.

Parameters:
- NUM_ENG, 4, number of engines (2..16).
- READ_LEN, 76, symbols per read; must match the engines.
- CNT_W, 32, width of the dispatched and completed counters.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enable  in  1  when low, no new read is accepted; in-flight reads continue
- s_read  in  Symbol[READ_LEN]  read symbols
- s_read_id  in  RID_W  read id
- s_read_last  in  1  last read of batch
- s_read_valid  in  1  read handshake valid
- s_read_ready  out  1  read handshake ready
- eng_read  out  Symbol[NUM_ENG][READ_LEN]  per-engine held read
- eng_read_id  out  RID_W[NUM_ENG]  per-engine held id
- eng_start  out  NUM_ENG  per-engine start pulse
- eng_finish  in  NUM_ENG  per-engine finish pulse
- batch_done  out  1  one-cycle pulse at end of batch
- dispatched_cnt  out  CNT_W  number of reads accepted
- completed_cnt  out  CNT_W  number of engine finishes counted
- err_spurious  out  1  sticky; an engine finish arrived while its slot was not in S_RUN

Behaviour:
- Reset (synchronous, rst high at posedge):
  - all slots go to S_FREE; rr_ptr=0; last_seen=0.
  - eng_start=0, batch_done=0, both counters=0, err_spurious=0.
  - eng_read and eng_read_id reset to sym_N and 0.
  - s_read_ready=0 during the reset cycle.
  - Reset mid-operation abandons in-flight reads. No finish is expected afterwards; engines are reset by the same rst.
- Per-slot state machine:
  - S_FREE -> S_LOAD when the slot is granted on an accepted handshake. eng_read[k] and eng_read_id[k] are loaded on that edge.
  - S_LOAD -> S_RUN after exactly 1 cycle. eng_start[k]=1 only while the slot is in S_LOAD, so start is a registered 1-cycle pulse.
  - Buffers are not modified in S_LOAD or S_RUN. The engine samples its read input on every idle cycle including the start cycle, so the buffer is stable for at least 1 cycle before start and until finish.
  - S_RUN -> S_FREE on eng_finish[k]. The slot is grantable on the cycle after the finish.
- Arbitration:
  - s_read_ready = enable && (any slot in S_FREE) && !rst. It is computed from registered state only and does not depend on s_read_valid.
  - Grant goes to the first S_FREE slot at or after rr_ptr, searching modulo NUM_ENG.
  - On accept, rr_ptr <= grant+1, wrapping from NUM_ENG-1 to 0.
  - At most one accept per cycle.
- Latency: from accept to eng_start is 1 cycle. A back-to-back stream fills all free engines in consecutive cycles.
- Counters:
  - dispatched_cnt increments by 1 per accept.
  - completed_cnt increments by 1 per eng_finish bit seen in S_RUN. Simultaneous finishes are summed (popcount).
  - Both counters wrap modulo 2^CNT_W.
- Batch end:
  - Accepting a read with s_read_last=1 sets last_seen.
  - batch_done pulses for 1 cycle on the first cycle where last_seen=1 and all slots are S_FREE; last_seen clears on that edge.
  - A new batch's first read may be accepted in the same cycle batch_done is high. In that case the accepted read does not re-trigger the finished batch.
- Simultaneous events:
  - A finish on slot a and an accept granted to slot b≠a in the same cycle are both honoured.
  - A finish on slot a is never granted in the same cycle, because a is still S_RUN.
- Errors:
  - eng_finish[k] while slot k is in S_FREE or S_LOAD sets err_spurious. Only rst clears it.
  - That finish is ignored: no state change, not counted.

Decomposition:
- Package BwaMemDefines holds Symbol, sym_N and RID_W (already defined).
- Add the slot-state enum to the package: S_FREE, S_LOAD, S_RUN (2 bits).
- One sub-module, rr_arbiter #(N). Inputs: request vector and pointer. Outputs: one-hot grant and a grant_valid flag. It is purely combinational; rr_ptr is registered in read_dispatch.

Test Plan:
- Fill: NUM_ENG=4. Send 4 reads back-to-back (ids 10..13). Engines 0..3 receive start at cycles 1..4 after each accept with matching ids; the 5th read sees s_read_ready=0 until any finish.
- Round-robin and finish:
  - Finish engine 2 only, then send id 20. It goes to engine 2 with start 1 cycle after accept; ready is low in the finish cycle, high the next.
  - Then finish engines 0 and 3 simultaneously. Next two reads go to 3 then 0 (rr_ptr=3); completed_cnt increases by 2 in one cycle.
- Buffer stability: toggle s_read contents while slots run. eng_read[k] stays bit-identical from the load edge through the finish pulse.
- Batch: 3 reads with last on the 3rd; finish in order 1,0,2. batch_done pulses exactly once, 1 cycle after the final finish edge, with dispatched_cnt=3 and completed_cnt=3.
- Enable and reset:
  - Drop enable with 2 free slots; ready=0 and no accept.
  - Assert rst while 2 engines are running. All outputs return to reset values next cycle; a later eng_finish sets err_spurious=1 and does not change completed_cnt.
- Counter wrap: preload dispatched_cnt to 2^CNT_W-1 via force; one accept makes it read 0.
